// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory bus arbiter.
//  - arbiter state encoding (2-bit)
//  - reset / enable level constants used by the arbiter datapath
//  - helper to size the byte-select field from a data width
package mem_bus_arbiter_pkg;

  // Arbiter FSM: idle, or owning the bus on behalf of MEM or IF.
  typedef enum logic [1:0] {
    ArbIdle   = 2'd0,
    ArbBusMem = 2'd1,
    ArbBusIf  = 2'd2
  } arb_state_e;

  // Active level of the reset input and of request/ack strobes.
  localparam logic RstEnable  = 1'b1;
  localparam logic ChipEnable = 1'b1;

  // Number of byte lanes for a given data width.
  function automatic int unsigned bus_sel_width(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Purpose : shares one single-port memory bus between instruction fetch and the MEM stage, MEM first.
// Latency : request seen at edge N drives bus_req_o from N+1; bus_ack_i at edge M gives requester ack in cycle M+1.
// Backpr. : requests are held by the core until acked; stallreq_o freezes the pipeline while any request is unserved.
//
// Ports
//  clk, rst                      clock, asynchronous active-high reset
//  if_req_i/if_addr_i            fetch request (held until if_ack_o or flush)
//  if_data_o/if_ack_o            fetched word, one-cycle completion pulse
//  mem_req_i/we/sel/addr/wdata   load/store request (held until mem_ack_o)
//  mem_rdata_o/mem_ack_o         load data, one-cycle completion pulse
//  flush_i                       pipeline flush, cancels fetches only
//  bus_req/we/sel/addr/wdata_o   registered bus command, held until bus_ack_i
//  bus_rdata_i/bus_ack_i         bus response, ack is a single cycle
//  stallreq_o                    combinational stall request to pipeline control
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port
  input  logic              if_req_i,
  input  logic [AW-1:0]     if_addr_i,
  output logic [DW-1:0]     if_data_o,
  output logic              if_ack_o,
  // MEM stage port
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [DW/8-1:0]   mem_sel_i,
  input  logic [AW-1:0]     mem_addr_i,
  input  logic [DW-1:0]     mem_wdata_i,
  output logic [DW-1:0]     mem_rdata_o,
  output logic              mem_ack_o,
  // pipeline control
  input  logic              flush_i,
  output logic              stallreq_o,
  // external bus
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [DW/8-1:0]   bus_sel_o,
  output logic [AW-1:0]     bus_addr_o,
  output logic [DW-1:0]     bus_wdata_o,
  input  logic [DW-1:0]     bus_rdata_i,
  input  logic              bus_ack_i
);

  localparam int SW = bus_sel_width(DW);
  localparam logic [SW-1:0] BusSelAll = '1;

  // Command captured at grant time and replayed on the bus until acked.
  typedef struct packed {
    logic          we;
    logic [SW-1:0] sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } bus_cmd_t;

  arb_state_e    state_q,     state_d;
  logic          bus_req_q,   bus_req_d;
  bus_cmd_t      cmd_q,       cmd_d;
  logic          if_ack_q,    if_ack_d;
  logic          mem_ack_q,   mem_ack_d;
  logic [DW-1:0] if_data_q,   if_data_d;
  logic [DW-1:0] mem_rdata_q, mem_rdata_d;
  logic          discard_q,   discard_d;

  // A request whose ack is pulsing this cycle is still held high by the
  // requester (it only drops it after seeing the ack), so it must not be
  // granted a second time.
  logic mem_pending;
  logic if_pending;

  assign mem_pending = mem_req_i & ~mem_ack_q;
  assign if_pending  = if_req_i & ~if_ack_q & ~flush_i;

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    cmd_d       = cmd_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    discard_d   = discard_q;

    case (state_q)
      ArbIdle: begin
        discard_d = 1'b0;
        // MEM belongs to the older instruction, so it always wins a tie.
        if (mem_pending) begin
          state_d     = ArbBusMem;
          bus_req_d   = ChipEnable;
          cmd_d.we    = mem_we_i;
          cmd_d.sel   = mem_sel_i;
          cmd_d.addr  = mem_addr_i;
          cmd_d.wdata = mem_wdata_i;
        end else if (if_pending) begin
          state_d     = ArbBusIf;
          bus_req_d   = ChipEnable;
          cmd_d.we    = 1'b0;
          cmd_d.sel   = BusSelAll;
          cmd_d.addr  = if_addr_i;
          cmd_d.wdata = '0;
        end
      end

      // Loads and stores are already committed: flush has no effect here.
      ArbBusMem: begin
        if (bus_ack_i) begin
          state_d     = ArbIdle;
          bus_req_d   = 1'b0;
          mem_ack_d   = ChipEnable;
          mem_rdata_d = bus_rdata_i;
        end
      end

      // The bus has no abort, so a flushed fetch still runs to completion;
      // its result is simply dropped. A flush coinciding with the ack counts.
      ArbBusIf: begin
        if (bus_ack_i) begin
          state_d   = ArbIdle;
          bus_req_d = 1'b0;
          discard_d = 1'b0;
          if (!(discard_q || flush_i)) begin
            if_ack_d  = ChipEnable;
            if_data_d = bus_rdata_i;
          end
        end else if (flush_i) begin
          discard_d = 1'b1;
        end
      end

      default: begin
        state_d   = ArbIdle;
        bus_req_d = 1'b0;
        discard_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q     <= ArbIdle;
      bus_req_q   <= 1'b0;
      cmd_q       <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      cmd_q       <= cmd_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      discard_q   <= discard_d;
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = cmd_q.we;
  assign bus_sel_o   = cmd_q.sel;
  assign bus_addr_o  = cmd_q.addr;
  assign bus_wdata_o = cmd_q.wdata;

  assign if_ack_o    = if_ack_q;
  assign if_data_o   = if_data_q;
  assign mem_ack_o   = mem_ack_q;
  assign mem_rdata_o = mem_rdata_q;

  // Stall while anything is unserved; a flushed fetch no longer counts.
  assign stallreq_o = (mem_req_i & ~mem_ack_o) | (if_req_i & ~if_ack_o & ~flush_i);

endmodule
